// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
// No logic; imported by the sequencer top.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int SA_N  = 4;
  localparam int SA_KW = 8;
  localparam int SA_AW = 8;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage valid shift register, one tap per stage (tap i = din delayed i+1 cycles).
// One cycle per stage; no backpressure, free-running.
module skew_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Tile sequencer for an NxN output-stationary systolic array: clear, skewed feed, flush, row drain, done.
// Tile takes k+3N+1 cycles after the accepting edge; start is ignored while busy (no queueing).
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int KW = SA_KW,
  parameter int AW = SA_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  output logic                 busy,
  output logic                 done,
  output logic                 a_rd_en,
  output logic                 b_rd_en,
  output logic [AW-1:0]        a_rd_addr,
  output logic [AW-1:0]        b_rd_addr,
  output logic [N-1:0]         a_vld,
  output logic [N-1:0]         b_vld,
  output logic                 pe_clr,
  output logic                 out_vld,
  output logic [$clog2(N)-1:0] out_row
);

  localparam int RW = $clog2(N);
  // One counter serves FEED steps, FLUSH cycles (up to 2N-2) and DRAIN rows.
  localparam int CW = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_k != '0) begin
              k_q   <= cfg_k;
              state <= CLEAR;
            end else begin
              state <= DONE;
            end
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= FEED;
        end
        FEED: begin
          if (cnt[KW-1:0] == k_q - 1'b1) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode registered state, so async reset zeroes them immediately.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pe_clr    = (state == CLEAR);
  assign a_rd_en   = (state == FEED);
  assign b_rd_en   = (state == FEED);
  assign a_rd_addr = a_rd_en ? AW'(cnt[KW-1:0]) : '0;
  assign b_rd_addr = b_rd_en ? AW'(cnt[KW-1:0]) : '0;
  assign out_vld   = (state == DRAIN);
  assign out_row   = out_vld ? cnt[RW-1:0] : '0;

  skew_line #(.DEPTH(N)) u_skew_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a_rd_en),
    .taps (a_vld)
  );

  skew_line #(.DEPTH(N)) u_skew_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b_rd_en),
    .taps (b_vld)
  );

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq (N=4, KW=8, AW=8); expectations come from the tile timing table.
module tb_systolic_seq;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int AW = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        cfg_k;
  logic                 busy;
  logic                 done;
  logic                 a_rd_en;
  logic                 b_rd_en;
  logic [AW-1:0]        a_rd_addr;
  logic [AW-1:0]        b_rd_addr;
  logic [N-1:0]         a_vld;
  logic [N-1:0]         b_vld;
  logic                 pe_clr;
  logic                 out_vld;
  logic [$clog2(N)-1:0] out_row;

  int n_assert;
  int n_fail;

  systolic_seq #(.N(N), .KW(KW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_k     (cfg_k),
    .busy      (busy),
    .done      (done),
    .a_rd_en   (a_rd_en),
    .b_rd_en   (b_rd_en),
    .a_rd_addr (a_rd_addr),
    .b_rd_addr (b_rd_addr),
    .a_vld     (a_vld),
    .b_vld     (b_vld),
    .pe_clr    (pe_clr),
    .out_vld   (out_vld),
    .out_row   (out_row)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at T+%0d: observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Expected outputs in cycle T+c of a tile with k steps; c=0 means idle/reset (all zero).
  task automatic check_cycle(input int c, input int k);
    int          last_c;
    logic        feed;
    logic        ov;
    logic [N-1:0] vexp;
    last_c = (k == 0) ? 1 : k + 3 * N + 1;
    feed   = (k > 0) && (c >= 2) && (c <= k + 1);
    ov     = (k > 0) && (c >= k + 2 * N + 1) && (c <= k + 3 * N);
    for (int i = 0; i < N; i++) begin
      vexp[i] = (k > 0) && (c >= 3 + i) && (c <= k + 2 + i);
    end
    chk("busy",      c, 32'(busy),      32'((c >= 1) && (c <= last_c)));
    chk("done",      c, 32'(done),      32'((c >= 1) && (c == last_c)));
    chk("pe_clr",    c, 32'(pe_clr),    32'((k > 0) && (c == 1)));
    chk("a_rd_en",   c, 32'(a_rd_en),   32'(feed));
    chk("b_rd_en",   c, 32'(b_rd_en),   32'(feed));
    chk("a_rd_addr", c, 32'(a_rd_addr), feed ? 32'(c - 2) : 32'd0);
    chk("b_rd_addr", c, 32'(b_rd_addr), feed ? 32'(c - 2) : 32'd0);
    chk("a_vld",     c, 32'(a_vld),     32'(vexp));
    chk("b_vld",     c, 32'(b_vld),     32'(vexp));
    chk("out_vld",   c, 32'(out_vld),   32'(ov));
    chk("out_row",   c, 32'(out_row),   ov ? 32'(c - (k + 2 * N + 1)) : 32'd0);
  endtask

  // Call away from a clock edge; returns at the negedge of the idle cycle after done.
  task automatic run_tile(input int k, input bit hold);
    start = 1'b1;
    cfg_k = KW'(k);
    @(posedge clk);
    #1;
    start = hold;
    if (hold) cfg_k = 8'hAA;
    for (int c = 1; c <= ((k == 0) ? 2 : k + 3 * N + 2); c++) begin
      @(negedge clk);
      check_cycle(c, k);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    cfg_k = '0;

    // Mid-cycle reset assertion, then idle with start low.
    #2 rst = 1'b0;
    #1 check_cycle(0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_cycle(0, 0);
    end

    run_tile(4, 1'b0);
    run_tile(0, 1'b0);

    // start held through a k=2 tile; next accept only in the idle cycle after done.
    run_tile(2, 1'b1);
    run_tile(3, 1'b0);

    // Reset during FEED step 3 of a k=8 tile.
    start = 1'b1;
    cfg_k = 8'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_cycle(c, 8);
    end
    #2 rst = 1'b0;
    #1 check_cycle(0, 8);
    repeat (2) begin
      @(negedge clk);
      check_cycle(0, 8);
    end
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_cycle(0, 8);
    end
    run_tile(5, 1'b0);

    run_tile(255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
